// File: rtl/seq_matrix_mult.sv
// rtl/seq_matrix_mult.sv - sequential SIZExSIZE matrix multiplier with one shared MAC
//
// Computes C = A x B one element at a time, streaming each C[i][j] out in
// row-major order behind a valid/ready handshake.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   START      begin a new job (taken only while IN_READY=1)
//   _A, _B     operand matrices, row-major, element (r,c) at (r*SIZE+c)*BITS +: BITS
//   IN_READY   idle, START will be accepted
//   OUT_       result element C[OUT_ROW][OUT_COL], sign-extended in signed mode
//   OUT_ROW    row index of OUT_
//   OUT_COL    column index of OUT_
//   OUT_VALID  OUT_/OUT_ROW/OUT_COL are valid and held until OUT_READY
//   OUT_READY  consumer accepts the current element
//   DONE       one-cycle pulse after the final element is accepted
module seq_matrix_mult #(
  parameter int BITS   = 2,
  parameter int SIZE   = 4,
  parameter int SIGNED = 0,
  localparam int ACC_W = 2*BITS + $clog2(SIZE),
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [BITS*SIZE*SIZE-1:0] _A,
  input  logic [BITS*SIZE*SIZE-1:0] _B,
  output logic                      IN_READY,
  output logic [ACC_W-1:0]          OUT_,
  output logic [IDX_W-1:0]          OUT_ROW,
  output logic [IDX_W-1:0]          OUT_COL,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

  logic [1:0]                state_q, state_d;
  logic [BITS*SIZE*SIZE-1:0] a_q, a_d;
  logic [BITS*SIZE*SIZE-1:0] b_q, b_d;
  logic [IDX_W-1:0]          i_q, i_d;
  logic [IDX_W-1:0]          j_q, j_d;
  logic [IDX_W-1:0]          k_q, k_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [ACC_W-1:0]          out_q, out_d;
  logic                      done_q, done_d;

  logic [BITS-1:0]  a_el, b_el;
  logic             a_sx, b_sx;
  logic [ACC_W-1:0] a_ext, b_ext, prod, sum;

  // Operand fetch for the current MAC step: A[i][k] and B[k][j].
  always_comb begin
    a_el  = a_q[(int'(i_q)*SIZE + int'(k_q))*BITS +: BITS];
    b_el  = b_q[(int'(k_q)*SIZE + int'(j_q))*BITS +: BITS];
    a_sx  = (SIGNED != 0) && a_el[BITS-1];
    b_sx  = (SIGNED != 0) && b_el[BITS-1];
    a_ext = {{(ACC_W-BITS){a_sx}}, a_el};
    b_ext = {{(ACC_W-BITS){b_sx}}, b_el};
    // Low ACC_W bits of the product are exact for both unsigned and two's-complement.
    prod  = a_ext * b_ext;
    sum   = acc_q + prod;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = _A;
          b_d     = _B;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = sum;
        k_d   = k_q + 1'b1;
        if (k_q == IDX_LAST) begin
          out_d   = sum;
          k_d     = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (OUT_READY) begin
          if (i_q == IDX_LAST && j_q == IDX_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            if (j_q == IDX_LAST) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
            acc_d   = '0;
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_EMIT);
  assign OUT_      = out_q;
  assign OUT_ROW   = i_q;
  assign OUT_COL   = j_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_seq_matrix_mult.sv
// tb/tb_seq_matrix_mult.sv - directed self-checking bench for seq_matrix_mult
module tb_seq_matrix_mult;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        OUT_READY;
  logic [31:0] a_in, b_in;

  logic       u_in_ready, u_valid, u_done;
  logic [5:0] u_out;
  logic [1:0] u_row, u_col;
  logic       s_in_ready, s_valid, s_done;
  logic [5:0] s_out;
  logic [1:0] s_row, s_col;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_m [16];

  always #5 CLK = ~CLK;

  seq_matrix_mult #(.BITS(2), .SIZE(4), .SIGNED(0)) u_dut (
    .CLK(CLK), .RST(RST), .START(START), ._A(a_in), ._B(b_in),
    .IN_READY(u_in_ready), .OUT_(u_out), .OUT_ROW(u_row), .OUT_COL(u_col),
    .OUT_VALID(u_valid), .OUT_READY(OUT_READY), .DONE(u_done)
  );

  seq_matrix_mult #(.BITS(2), .SIZE(4), .SIGNED(1)) u_sdut (
    .CLK(CLK), .RST(RST), .START(START), ._A(a_in), ._B(b_in),
    .IN_READY(s_in_ready), .OUT_(s_out), .OUT_ROW(s_row), .OUT_COL(s_col),
    .OUT_VALID(s_valid), .OUT_READY(OUT_READY), .DONE(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // kind 0: A=identity, B[r][c]=(r+c)%4 -> C=B
  // kind 1: all 3            -> every C = 4*9  = 36
  // kind 2: all -2 (signed)  -> every C = 4*4  = 16
  // kind 3: A=-2, B=1        -> every C = 4*-2 = -8 = 6'h38
  task automatic fill(input int kind);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (kind)
          0: begin
            a_in[(r*4+c)*2 +: 2] = (r == c) ? 2'd1 : 2'd0;
            b_in[(r*4+c)*2 +: 2] = 2'((r + c) % 4);
            exp_m[r*4+c]         = 6'((r + c) % 4);
          end
          1: begin
            a_in[(r*4+c)*2 +: 2] = 2'd3;
            b_in[(r*4+c)*2 +: 2] = 2'd3;
            exp_m[r*4+c]         = 6'd36;
          end
          2: begin
            a_in[(r*4+c)*2 +: 2] = 2'b10;
            b_in[(r*4+c)*2 +: 2] = 2'b10;
            exp_m[r*4+c]         = 6'h10;
          end
          default: begin
            a_in[(r*4+c)*2 +: 2] = 2'b10;
            b_in[(r*4+c)*2 +: 2] = 2'b01;
            exp_m[r*4+c]         = 6'h38;
          end
        endcase
      end
    end
  endtask

  // Caller asserts START at a negedge (cycle 0); this follows the job until DONE.
  task automatic collect(input string name, input bit sgn, input bit bp,
                         input bit hold, input bit poke);
    int cyc = 0;
    int hs = 0;
    int first = -1;
    int done_cyc = -1;
    bit stall = 1'b0;
    logic [5:0] sv_out = '0;
    logic [1:0] sv_row = '0, sv_col = '0;
    logic [5:0] o;
    logic [1:0] rw, cl;
    logic rdy;
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge CLK);
      cyc++;
      if (!hold) START = 1'b0;
      if (poke && cyc == 2) begin
        START = 1'b1;
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'hFFFF_FFFF;
      end
      if (poke && cyc == 4) START = 1'b0;
      o  = sgn ? s_out : u_out;
      rw = sgn ? s_row : u_row;
      cl = sgn ? s_col : u_col;
      if (cyc == 1) chk({name, "_busy_after_start"}, {31'd0, u_in_ready}, 32'd0);
      if (stall) begin
        chk({name, "_hold_out"}, {26'd0, o}, {26'd0, sv_out});
        chk({name, "_hold_row"}, {30'd0, rw}, {30'd0, sv_row});
        chk({name, "_hold_col"}, {30'd0, cl}, {30'd0, sv_col});
      end
      if (u_valid && first < 0) first = cyc;
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      OUT_READY = rdy;
      if (u_valid && rdy) begin
        if (hs < 16) begin
          chk($sformatf("%s_val%0d", name, hs), {26'd0, o}, {26'd0, exp_m[hs]});
          chk($sformatf("%s_row%0d", name, hs), {30'd0, rw}, 32'(hs / 4));
          chk($sformatf("%s_col%0d", name, hs), {30'd0, cl}, 32'(hs % 4));
        end
        hs++;
      end
      stall  = u_valid && !rdy;
      sv_out = o;
      sv_row = rw;
      sv_col = cl;
      if (u_done) done_cyc = cyc;
    end
    chk({name, "_done_seen"}, {31'd0, (done_cyc >= 0)}, 32'd1);
    chk({name, "_handshakes"}, 32'(hs), 32'd16);
    chk({name, "_first_valid_cycle"}, 32'(first), 32'd5);
    chk({name, "_ready_at_done"}, {31'd0, u_in_ready}, 32'd1);
    if (!bp) chk({name, "_done_cycle"}, 32'(done_cyc), 32'd81);
    if (!hold) begin
      @(negedge CLK);
      chk({name, "_done_one_cycle"}, {31'd0, u_done}, 32'd0);
      chk({name, "_idle_after"}, {31'd0, u_in_ready}, 32'd1);
    end
  endtask

  task automatic kick();
    @(negedge CLK);
    START = 1'b1;
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    OUT_READY = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", {31'd0, u_in_ready}, 32'd1);
    chk("rst_valid", {31'd0, u_valid}, 32'd0);
    chk("rst_done", {31'd0, u_done}, 32'd0);
    chk("rst_out", {26'd0, u_out}, 32'd0);
    chk("rst_row", {30'd0, u_row}, 32'd0);
    chk("rst_col", {30'd0, u_col}, 32'd0);
    RST = 1'b0;

    fill(0); kick(); collect("ident", 1'b0, 1'b0, 1'b0, 1'b0);
    fill(1); kick(); collect("umax", 1'b0, 1'b0, 1'b0, 1'b0);
    fill(2); kick(); collect("sneg2", 1'b1, 1'b0, 1'b0, 1'b0);
    fill(3); kick(); collect("sneg2x1", 1'b1, 1'b0, 1'b0, 1'b0);
    fill(0); kick(); collect("bp", 1'b0, 1'b1, 1'b0, 1'b0);
    fill(0); kick(); collect("busy_start", 1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-run reset: element (1,2) is index 6, its MAC spans cycles 31..35.
    fill(0); kick();
    for (int c = 1; c <= 33; c++) begin
      @(negedge CLK);
      START = 1'b0;
      OUT_READY = 1'b1;
      if (c == 33) RST = 1'b1;
    end
    @(negedge CLK);
    chk("midrst_valid", {31'd0, u_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, u_in_ready}, 32'd1);
    chk("midrst_done", {31'd0, u_done}, 32'd0);
    chk("midrst_out", {26'd0, u_out}, 32'd0);
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("midrst_no_done", {31'd0, u_done}, 32'd0);
    end
    fill(0); kick(); collect("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: START stays high through DONE, second job taken in the DONE cycle.
    fill(0); kick();
    collect("b2b_first", 1'b0, 1'b0, 1'b1, 1'b0);
    collect("b2b_second", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
